// File: rtl/prod_accum_pkg.sv
// Shared widths, accumulator limits and FSM encoding for the product accumulator
// and its saturating adder.
package prod_accum_pkg;

  localparam int DEF_IN_W  = 32;
  localparam int DEF_ACC_W = 40;
  localparam int DEF_CNT_W = 10;

  localparam logic signed [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic signed [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/prod_accum_sat_add.sv
// Combinational signed saturating adder: ACC_W accumulator plus sign-extended
// IN_W operand, clamped back to ACC_W with an overflow flag.
module sat_add #(
  parameter int ACC_W = prod_accum_pkg::DEF_ACC_W,
  parameter int IN_W  = prod_accum_pkg::DEF_IN_W
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [IN_W-1:0]  b,
  output logic signed [ACC_W-1:0] y,
  output logic                    ovf
);

  localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] sum;

  // One guard bit is enough: the top two bits disagree exactly when the sum
  // left the ACC_W range, and the guard bit gives the direction.
  assign sum = {a[ACC_W-1], a} + {{(ACC_W+1-IN_W){b[IN_W-1]}}, b};

  always_comb begin
    // NOTE: every output gets a value on every path so no latch is inferred.
    y   = sum[ACC_W-1:0];
    ovf = 1'b0;
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      ovf = 1'b1;
      y   = sum[ACC_W] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/prod_accum.sv
// Frames the signed product stream from the multiplier into saturated sums,
// one result per in_last frame, delivered over a valid/ready handshake.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_last,
  input  logic                    in_abort,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_sat,
  output logic [CNT_W-1:0]        out_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sat_q, sat_d;
  logic signed [ACC_W-1:0] out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic [CNT_W-1:0]        out_count_q, out_count_d;

  logic signed [ACC_W-1:0] sum;
  logic                    sum_ovf;
  logic                    accept;

  sat_add #(
    .ACC_W(ACC_W),
    .IN_W (IN_W)
  ) u_sat_add (
    .a  (acc_q),
    .b  (in_data),
    .y  (sum),
    .ovf(sum_ovf)
  );

  assign out_valid = (state_q == HOLD);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready && !in_abort;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;

    if (state_q == HOLD && out_ready) begin
      state_d = ACCUM;
    end

    // Abort only touches the partial frame; a pending result stays in HOLD.
    if (in_abort) begin
      acc_d = '0;
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (accept) begin
      if (in_last) begin
        out_data_d  = sum;
        out_sat_d   = sat_q || sum_ovf;
        out_count_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        state_d     = HOLD;
        acc_d       = '0;
        cnt_d       = '0;
        sat_d       = 1'b0;
      end else begin
        acc_d = sum;
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        sat_d = sat_q || sum_ovf;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

endmodule
